// File: rtl/cr_kme_fifo_arb_pkg.sv
// Shared widths and the FIFO entry layout for the KME tag FIFO write arbiter.
package cr_kme_fifo_arb_pkg;

  localparam int KME_ARB_ID_W  = 2;
  localparam int KME_ARB_PLD_W = 2;

  // One FIFO entry: owner ID in the upper bits, requester payload below.
  typedef struct packed {
    logic [KME_ARB_ID_W-1:0]  id;
    logic [KME_ARB_PLD_W-1:0] payload;
  } kme_arb_entry_t;

endpackage

// File: rtl/cr_kme_rr_pick.sv
// Round-robin picker: first eligible requester scanning ptr, ptr+1, ... mod 4.
module cr_kme_rr_pick (
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Scan from the pointer and stop at the first eligible index.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 0; off < 4; off++) begin
      cand = ptr + 2'(off);
      if (!any && elig[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_kme_fifo_arb.sv
// Write-side round-robin arbiter and per-requester credit scheduler for the
// KME tag FIFO. Holds the run flag, rotation pointer, resident counters and
// sticky error flags.
module cr_kme_fifo_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [2*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [3:0]         fifo_in,
  output logic               fifo_in_valid,
  input  logic               fifo_in_stall,
  input  logic [3:0]         fifo_out,
  input  logic               fifo_out_valid,
  input  logic               fifo_out_ack,
  input  logic               fifo_overflow,
  input  logic               fifo_underflow,
  output logic [2*N_REQ-1:0] outstanding,
  output logic               credit_err,
  output logic               fifo_err
);

  logic                    run;
  logic [1:0]              ptr;
  logic [1:0]              cnt [N_REQ];
  logic [N_REQ-1:0]        elig;
  logic [N_REQ-1:0]        pick_gnt;
  logic [1:0]              pick_idx;
  logic                    pick_any;
  logic                    grant;
  logic                    pop;
  logic [KME_ARB_ID_W-1:0] pop_id;
  logic [N_REQ-1:0]        pop_hit;
  logic [KME_ARB_PLD_W-1:0] win_pld;
  logic                    credit_underrun;
  kme_arb_entry_t          entry;
  logic                    unused_head_pld;

  // The head payload bits carry no meaning for credit return.
  assign unused_head_pld = ^fifo_out[1:0];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign elig[gi]                 = req_valid[gi] & (cnt[gi] < 2'(MAX_OUT));
    assign pop_hit[gi]              = pop & (pop_id == 2'(gi));
    assign outstanding[2*gi +: 2]   = cnt[gi];
  end

  cr_kme_rr_pick u_pick (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign grant  = run & enable & ~fifo_in_stall & pick_any;
  assign pop    = fifo_out_valid & fifo_out_ack;
  assign pop_id = fifo_out[3:2];

  // Select the winning requester's payload.
  always_comb begin
    win_pld = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) win_pld = req_data[2*i +: 2];
    end
  end

  assign entry.id      = pick_idx;
  assign entry.payload = win_pld;

  assign req_ready     = grant ? pick_gnt : '0;
  assign fifo_in_valid = grant;
  assign fifo_in       = grant ? entry : '0;

  // A pop with nothing resident and no offsetting grant is a credit underrun.
  always_comb begin
    credit_underrun = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pop_hit[i] && !req_ready[i] && cnt[i] == 2'd0) credit_underrun = 1'b1;
    end
  end

  // Run flag rises on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Pointer moves past the winner; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= '0;
    else if (grant) ptr <= pick_idx + 2'd1;
  end

  // Resident counters: +1 on grant, -1 on pop, unchanged when both or neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && !pop_hit[i])
          cnt[i] <= cnt[i] + 2'd1;
        else if (pop_hit[i] && !req_ready[i] && cnt[i] != 2'd0)
          cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err <= 1'b0;
      fifo_err   <= 1'b0;
    end else begin
      if (credit_underrun)                 credit_err <= 1'b1;
      if (fifo_overflow || fifo_underflow) fifo_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// Directed bench for cr_kme_fifo_arb with hand-computed expectations.
module tb_cr_kme_fifo_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req_valid;
  logic [7:0] req_data;
  logic [3:0] req_ready;
  logic [3:0] fifo_in;
  logic       fifo_in_valid;
  logic       fifo_in_stall;
  logic [3:0] fifo_out;
  logic       fifo_out_valid;
  logic       fifo_out_ack;
  logic       fifo_overflow;
  logic       fifo_underflow;
  logic [7:0] outstanding;
  logic       credit_err;
  logic       fifo_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cr_kme_fifo_arb #(.N_REQ(4), .MAX_OUT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_in        (fifo_in),
    .fifo_in_valid  (fifo_in_valid),
    .fifo_in_stall  (fifo_in_stall),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack   (fifo_out_ack),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .outstanding    (outstanding),
    .credit_err     (credit_err),
    .fifo_err       (fifo_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle where combinational outputs are stable.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] rdy, input logic [3:0] din);
    check_val({tag, "_rdy"}, 32'(req_ready), 32'(rdy));
    check_val({tag, "_vld"}, 32'(fifo_in_valid), 32'(rdy != 4'd0));
    check_val({tag, "_din"}, 32'(fifo_in), 32'(din));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // d3=0, d2=1, d1=3, d0=2
    rst_n          = 1'b0;
    enable         = 1'b0;
    req_valid      = 4'h0;
    req_data       = 8'b00_01_11_10;
    fifo_in_stall  = 1'b0;
    fifo_out       = 4'h0;
    fifo_out_valid = 1'b0;
    fifo_out_ack   = 1'b0;
    fifo_overflow  = 1'b0;
    fifo_underflow = 1'b0;
    step(); step();
    mid();
    chk_grant("rst", 4'h0, 4'h0);
    check_val("rst_out", 32'(outstanding), 32'h0);
    check_val("rst_cerr", 32'(credit_err), 32'h0);
    check_val("rst_ferr", 32'(fifo_err), 32'h0);

    // All four request; release reset. Run is still low this cycle.
    step();
    req_valid = 4'hF;
    enable    = 1'b1;
    rst_n     = 1'b1;
    mid(); chk_grant("run0", 4'h0, 4'h0);
    step(); mid(); chk_grant("rr0", 4'b0001, 4'h2);
    step(); mid(); chk_grant("rr1", 4'b0010, 4'h7);
    step(); mid(); chk_grant("rr2", 4'b0100, 4'h9);
    step(); mid(); chk_grant("rr3", 4'b1000, 4'hC);
    step();
    req_valid = 4'h0;
    check_val("rr_out", 32'(outstanding), 32'h55);

    // Only requester 2: one more grant reaches MAX_OUT, then blocked.
    req_valid = 4'b0100;
    mid(); chk_grant("r2_g", 4'b0100, 4'h9);
    step();
    check_val("r2_out", 32'(outstanding), 32'h65);
    mid(); chk_grant("r2_blk", 4'h0, 4'h0);
    step();
    fifo_out = 4'h9; fifo_out_valid = 1'b1; fifo_out_ack = 1'b1;
    mid(); chk_grant("r2_popcyc", 4'h0, 4'h0);
    step();
    fifo_out_valid = 1'b0; fifo_out_ack = 1'b0;
    check_val("r2_popout", 32'(outstanding), 32'h55);
    mid(); chk_grant("r2_regrant", 4'b0100, 4'h9);
    step();
    req_valid = 4'h0;
    check_val("r2_out2", 32'(outstanding), 32'h65);

    // Stall with all requests: nothing granted, pointer (3) holds.
    req_valid = 4'hF; fifo_in_stall = 1'b1;
    mid(); chk_grant("stall0", 4'h0, 4'h0);
    step(); mid(); chk_grant("stall1", 4'h0, 4'h0);
    step();
    fifo_in_stall = 1'b0;
    mid(); chk_grant("unstall", 4'b1000, 4'hC);
    step();
    req_valid = 4'h0;
    check_val("unstall_out", 32'(outstanding), 32'hA5);

    // Grant and pop of requester 1 together: count stays at 1.
    req_valid = 4'b0010; fifo_out = 4'h4; fifo_out_valid = 1'b1; fifo_out_ack = 1'b1;
    mid(); chk_grant("gp_g", 4'b0010, 4'h7);
    step();
    req_valid = 4'h0; fifo_out_valid = 1'b0; fifo_out_ack = 1'b0;
    check_val("gp_out", 32'(outstanding), 32'hA5);
    check_val("gp_cerr", 32'(credit_err), 32'h0);

    // Drain requester 3, then pop it once more with count 0.
    fifo_out = 4'hC; fifo_out_valid = 1'b1; fifo_out_ack = 1'b1;
    step(); check_val("d3_a", 32'(outstanding), 32'h65);
    step(); check_val("d3_b", 32'(outstanding), 32'h25);
    check_val("d3_cerr0", 32'(credit_err), 32'h0);
    step();
    check_val("d3_c", 32'(outstanding), 32'h25);
    check_val("d3_cerr1", 32'(credit_err), 32'h1);
    fifo_out_valid = 1'b0; fifo_out_ack = 1'b0;
    // Valid without ack is not a pop.
    fifo_out_valid = 1'b1;
    step();
    fifo_out_valid = 1'b0;
    check_val("noack_out", 32'(outstanding), 32'h25);
    check_val("ferr_pre", 32'(fifo_err), 32'h0);
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    check_val("ferr_ovf", 32'(fifo_err), 32'h1);
    step();
    check_val("ferr_sticky", 32'(fifo_err), 32'h1);
    check_val("cerr_sticky", 32'(credit_err), 32'h1);

    // Disabled: no grants even with eligible requesters.
    enable = 1'b0; req_valid = 4'hF;
    mid(); chk_grant("dis", 4'h0, 4'h0);
    step();
    enable = 1'b1;
    // ptr=0 after the unstall grant and gp grant moved it to 2; elig 0,1,3.
    mid(); chk_grant("pre_rst", 4'b1000, 4'hC);
    step();
    check_val("pre_rst_out", 32'(outstanding), 32'h65);

    // Asynchronous reset mid-cycle clears everything at once.
    rst_n = 1'b0;
    #1;
    chk_grant("arst", 4'h0, 4'h0);
    check_val("arst_out", 32'(outstanding), 32'h0);
    check_val("arst_cerr", 32'(credit_err), 32'h0);
    check_val("arst_ferr", 32'(fifo_err), 32'h0);
    step();
    rst_n = 1'b1;
    mid(); chk_grant("post_run0", 4'h0, 4'h0);
    step(); mid(); chk_grant("post_g0", 4'b0001, 4'h2);
    step();
    req_valid = 4'h0;
    check_val("post_out", 32'(outstanding), 32'h01);
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    check_val("ferr_unf", 32'(fifo_err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
